alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one 2-stage ALU datapath between NUM_REQ requesters. The ALU has a registered input stage, a registered output stage, a fixed 2-cycle latency and no stall.
- Per cycle, grants at most one requester with round-robin fairness and drives the ALU operand inputs.
- A tag pipeline tracks which requester owns each in-flight operation, so each result is routed back to its owner.
- Illegal opcodes are screened out: the ALU never sees one, and the requester gets an error response.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ALU_LAT, 2, cycles from alu_valid_i high to matching alu_valid_o high; must equal the datapath latency.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; a handshake fires when valid && ready.
- req_aluop  in  NUM_REQ x 3  opcode: 0 and, 1 or, 2 not, 3 add, 4 sub, 5 shl, 6 shr, 7 illegal.
- req_a  in  NUM_REQ x 32  operand a.
- req_b  in  NUM_REQ x 32  operand b.
- resp_valid  out  NUM_REQ  one-cycle result pulse to the owning requester.
- resp_f  out  32  result; shared bus, qualified by resp_valid.
- resp_err  out  1  illegal-opcode flag, qualified by resp_valid.
- alu_aluop  out  3  to datapath.
- alu_a  out  32  to datapath.
- alu_b  out  32  to datapath.
- alu_valid_i  out  1  to datapath.
- alu_f  in  32  from datapath.
- alu_valid_o  in  1  from datapath.

Behaviour:
- Combinational issue path. Grant is computed from the current req_valid and the rr pointer. alu_* outputs and req_ready are combinational from the grant, because the ALU registers its inputs itself.
- At most one req_ready bit is high per cycle, and only for a requester whose req_valid is high. req_ready never depends on resp_valid; there is no response backpressure.
- Round robin:
  - Search order starts at rr_ptr+1 mod NUM_REQ.
  - On a handshake, rr_ptr <= granted index.
  - Reset value of rr_ptr is NUM_REQ-1, so requester 0 has first priority.
  - With no handshake, rr_ptr holds.
- Legal opcode (0..6) granted:
  - alu_valid_i=1, alu_aluop/alu_a/alu_b = the granted requester's fields.
  - Push {valid=1, id, err=0} into the tag pipeline.
- Opcode 7 granted:
  - Handshake completes, but alu_valid_i=0.
  - Push {valid=1, id, err=1}.
- No grant: alu_valid_i=0, push {valid=0}. alu_a, alu_b and alu_aluop are don't-care but are driven to 0 (no X propagation).
- Tag pipeline:
  - ALU_LAT-deep shift register, advancing every cycle.
  - The entry reaching the tail in cycle t corresponds to an issue in cycle t-ALU_LAT.
- Response, cycle-accurate: a tail entry with valid=1 produces, in that same cycle:
  - resp_valid[id]=1.
  - err=0: resp_f=alu_f, resp_err=0.
  - err=1: resp_f=0, resp_err=1.
  - Otherwise resp_valid=0, resp_f=0, resp_err=0.
- Latency: handshake in cycle t gives resp_valid in cycle t+ALU_LAT. Throughput is 1 operation per cycle. Back-to-back grants to the same requester are allowed.
- Consistency check (simulation assertion only):
  - tail valid && !err requires alu_valid_o=1.
  - tail !valid or err requires alu_valid_o=0, except in the ALU_LAT cycles after reset deassertion.
- Reset:
  - rr_ptr=NUM_REQ-1, all tag entries invalid.
  - All outputs 0 during rst: req_ready, resp_valid, resp_f, resp_err, alu_valid_i, alu_aluop, alu_a, alu_b.
  - The ALU itself has no reset, so alu_valid_o stale pulses within ALU_LAT cycles after reset are ignored, because the tail is invalid.
  - Operations in flight at reset are dropped silently; no response is produced for them.
- A requester holding req_valid with changing operands is legal. Only the fields sampled in the handshake cycle matter.

Decomposition:
- Package alu_pkg:
  - typedef enum logic [2:0] alu_op_t: ALU_AND..ALU_SHR, ALU_ILLEGAL=7.
  - localparam ALU_LATENCY=2.
  - typedef struct tag_t {valid, id, err}.
- Sub-module rr_arbiter (NUM_REQ): req vector plus advance enable in, one-hot grant plus index out, owns rr_ptr. The tag pipeline stays in alu_arbiter.

Test Plan:
- Single issue, reset then req0: add a=5, b=3 at t → req_ready[0]=1 at t; resp_valid[0]=1, resp_f=8, resp_err=0 at t+2.
- All four requesters valid continuously:
  - req0 and 0xF0F0F0F0, 0xFF00FF00; req1 sub 10, 3; req2 shl 1, 4; req3 not 0.
  - Grants follow 0,1,2,3,0..., one per cycle.
  - Responses in the same order 2 cycles later: 0xF000F000, 7, 16, 0xFFFFFFFF.
- Illegal op, req2 aluop=7: alu_valid_i=0 in the grant cycle; two cycles later resp_valid[2]=1, resp_err=1, resp_f=0.
- Wrap and fairness:
  - Only req1 and req3 valid → alternating grants 1,3,1,3.
  - Drop req3 → req1 is granted every cycle.
  - Sub 0-1 gives 0xFFFFFFFF; shr 0x80000000 by b=33 uses b[4:0]=1 and gives 0x40000000.
- Reset mid-flight: issue 2 ops, assert rst for 1 cycle on the next edge → no resp_valid for dropped ops, rr_ptr back to 3, first post-reset grant goes to req0.
- Idle: no req_valid for 10 cycles → alu_valid_i=0 and resp_valid=0 throughout, no assertion fires.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter: opcode enum, tag pipeline entry, datapath latency.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_AND     = 3'd0,
    ALU_OR      = 3'd1,
    ALU_NOT     = 3'd2,
    ALU_ADD     = 3'd3,
    ALU_SUB     = 3'd4,
    ALU_SHL     = 3'd5,
    ALU_SHR     = 3'd6,
    ALU_ILLEGAL = 3'd7
  } alu_op_t;

  // Registered input stage plus registered output stage in the shared datapath.
  localparam int ALU_LATENCY = 2;

  // Requester id field is sized for the largest supported NUM_REQ (8).
  localparam int ID_W = 3;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic            err;
  } tag_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    return op != ALU_ILLEGAL;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// Round-robin arbiter: one-hot grant among requesters, search starts after the last winner.
// Latency: grant is combinational from req_i and the registered pointer.
// Backpressure: none; pointer only moves to the winner when adv_i is high.
module rr_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               adv_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_vld_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand_idx;
  int               cand;

  // Priority search: first requesting index after ptr_q, wrapping around.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand     = (int'(ptr_q) + i) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!gnt_vld_o && req_i[cand_idx]) begin
        gnt_vld_o       = 1'b1;
        gnt_idx_o       = cand_idx;
        gnt_o[cand_idx] = 1'b1;
      end
    end
  end

  // Next pointer: remember the winner of a completed handshake, else hold.
  always_comb begin
    ptr_d = ptr_q;
    if (adv_i && gnt_vld_o) ptr_d = gnt_idx_o;
  end

  // Pointer register; reset to the last index so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= IDX_W'(NUM_REQ - 1);
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one 2-stage ALU among NUM_REQ requesters; illegal opcodes answered with an error.
// Latency: issue is combinational; response returns exactly ALU_LAT cycles after the handshake.
// Backpressure: one grant per cycle via req_ready; responses cannot be stalled.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ALU_LAT = ALU_LATENCY
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ-1:0][2:0] req_aluop,
  input  logic [NUM_REQ-1:0][31:0] req_a,
  input  logic [NUM_REQ-1:0][31:0] req_b,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic [31:0]             resp_f,
  output logic                    resp_err,
  output logic [2:0]              alu_aluop,
  output logic [31:0]             alu_a,
  output logic [31:0]             alu_b,
  output logic                    alu_valid_i,
  input  logic [31:0]             alu_f,
  input  logic                    alu_valid_o
);

  localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SETTLE_W = $clog2(ALU_LAT + 1);

  logic [NUM_REQ-1:0] req_gated;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_vld;
  tag_t               tag_d;
  tag_t               tag_q [ALU_LAT];
  tag_t               tail;
  logic [SETTLE_W-1:0] settle_q;

  // Masking requests during reset keeps every issue-side output at zero.
  assign req_gated = req_valid & {NUM_REQ{~rst}};

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_gated),
    .adv_i     (gnt_vld),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  // Issue: drive the ALU from the winner, or screen an illegal opcode into an error tag.
  always_comb begin
    req_ready   = gnt;
    alu_valid_i = 1'b0;
    alu_aluop   = '0;
    alu_a       = '0;
    alu_b       = '0;
    tag_d       = '0;
    if (gnt_vld) begin
      tag_d.valid = 1'b1;
      tag_d.id    = ID_W'(gnt_idx);
      if (op_is_legal(req_aluop[gnt_idx])) begin
        alu_valid_i = 1'b1;
        alu_aluop   = req_aluop[gnt_idx];
        alu_a       = req_a[gnt_idx];
        alu_b       = req_b[gnt_idx];
      end else begin
        tag_d.err = 1'b1;
      end
    end
  end

  // Tag shift register, lockstep with the ALU pipeline; reset drops in-flight ops.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < ALU_LAT; k++) tag_q[k] <= '0;
    end else begin
      tag_q[0] <= tag_d;
      for (int k = 1; k < ALU_LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  assign tail = tag_q[ALU_LAT-1];

  // Response: route the tail entry back to its owner on the shared result bus.
  always_comb begin
    resp_valid = '0;
    resp_f     = '0;
    resp_err   = 1'b0;
    if (!rst && tail.valid) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (tail.id == ID_W'(i)) resp_valid[i] = 1'b1;
      end
      if (tail.err) resp_err = 1'b1;
      else          resp_f   = alu_f;
    end
  end

  // Counts down the window after reset in which the unreset ALU may still emit stale pulses.
  always_ff @(posedge clk) begin
    if (rst)                 settle_q <= SETTLE_W'(ALU_LAT);
    else if (settle_q != '0) settle_q <= settle_q - 1'b1;
  end

  a_result_present: assert property (@(posedge clk) disable iff (rst)
    (tail.valid && !tail.err) |-> alu_valid_o);

  a_no_stray_result: assert property (@(posedge clk) disable iff (rst)
    (!(tail.valid && !tail.err) && settle_q == '0) |-> !alu_valid_o);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural 2-stage ALU attached to the datapath ports.
// Latency: checks responses exactly two cycles after each grant.
// Backpressure: exercises round-robin grant order under contention.
module tb_alu_arbiter;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       req_valid = '0;
  logic [3:0]       req_ready;
  logic [3:0][2:0]  req_aluop = '0;
  logic [3:0][31:0] req_a = '0;
  logic [3:0][31:0] req_b = '0;
  logic [3:0]       resp_valid;
  logic [31:0]      resp_f;
  logic             resp_err;
  logic [2:0]       alu_aluop;
  logic [31:0]      alu_a, alu_b;
  logic             alu_valid_i;
  logic [31:0]      alu_f;
  logic             alu_valid_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(4), .ALU_LAT(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_aluop   (req_aluop),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (resp_valid),
    .resp_f      (resp_f),
    .resp_err    (resp_err),
    .alu_aluop   (alu_aluop),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_valid_i (alu_valid_i),
    .alu_f       (alu_f),
    .alu_valid_o (alu_valid_o)
  );

  // Behavioural datapath: registered inputs, registered result, no reset.
  logic        s1_vld = 1'b0, s2_vld = 1'b0;
  logic [2:0]  s1_op = '0;
  logic [31:0] s1_a = '0, s1_b = '0, s2_f = '0;

  function automatic logic [31:0] alu_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~a;
      3'd3:    return a + b;
      3'd4:    return a - b;
      3'd5:    return a << sh;
      3'd6:    return a >> sh;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    s1_vld <= alu_valid_i;
    s1_op  <= alu_aluop;
    s1_a   <= alu_a;
    s1_b   <= alu_b;
    s2_vld <= s1_vld;
    s2_f   <= alu_calc(s1_op, s1_a, s1_b);
  end

  assign alu_f       = s2_f;
  assign alu_valid_o = s2_vld;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_aluop[r] = op;
    req_a[r]     = a;
    req_b[r]     = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [31:0] rr4_f [4] = '{32'hF000F000, 32'h7, 32'h10, 32'hFFFFFFFF};
  // Pointer sits at 2 after the illegal-op grant, so requester 3 wins first.
  logic [3:0]  wrap_gnt [7] = '{4'b1000, 4'b0010, 4'b1000, 4'b0010, 4'b0010, 4'b0010, 4'b0010};

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    // Reset: requests present but everything must stay at zero.
    for (int r = 0; r < 4; r++) set_req(r, 3'd3, 32'h1, 32'h1);
    req_valid = 4'hF;
    tick();
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_alu_vld", alu_valid_i, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_resp_vld", resp_valid, 0);
    check("rst_resp_f", resp_f, 0);
    tick();
    req_valid = '0;
    rst = 1'b0;

    // Single issue: req0 add 5+3.
    set_req(0, 3'd3, 32'd5, 32'd3);
    req_valid = 4'b0001;
    #1;
    check("one_ready", req_ready, 4'b0001);
    check("one_alu_vld", alu_valid_i, 1);
    check("one_alu_op", alu_aluop, 3);
    check("one_alu_a", alu_a, 5);
    check("one_alu_b", alu_b, 3);
    tick();
    req_valid = '0;
    #1;
    check("one_early", resp_valid, 0);
    tick();
    #1;
    check("one_rv", resp_valid, 4'b0001);
    check("one_f", resp_f, 8);
    check("one_err", resp_err, 0);
    tick();

    // Four-way contention after reset: grants 0,1,2,3 repeating.
    do_reset();
    set_req(0, 3'd0, 32'hF0F0F0F0, 32'hFF00FF00);
    set_req(1, 3'd4, 32'd10, 32'd3);
    set_req(2, 3'd5, 32'd1, 32'd4);
    set_req(3, 3'd2, 32'd0, 32'd0);
    for (int k = 0; k < 10; k++) begin
      req_valid = (k < 8) ? 4'hF : 4'h0;
      #1;
      if (k < 8) check("rr4_gnt", req_ready, 32'd1 << (k % 4));
      if (k >= 2) begin
        check("rr4_rv", resp_valid, 32'd1 << ((k - 2) % 4));
        check("rr4_f", resp_f, rr4_f[(k - 2) % 4]);
        check("rr4_err", resp_err, 0);
      end
      tick();
    end

    // Illegal opcode from req2: handshake without ALU issue, error response.
    set_req(2, 3'd7, 32'd123, 32'd45);
    req_valid = 4'b0100;
    #1;
    check("ill_ready", req_ready, 4'b0100);
    check("ill_alu_vld", alu_valid_i, 0);
    tick();
    req_valid = '0;
    #1;
    check("ill_early", resp_valid, 0);
    tick();
    #1;
    check("ill_rv", resp_valid, 4'b0100);
    check("ill_err", resp_err, 1);
    check("ill_f", resp_f, 0);
    tick();

    // Wrap and fairness: req1/req3 alternate, then req1 alone back to back.
    set_req(1, 3'd4, 32'h0, 32'h1);
    set_req(3, 3'd6, 32'h80000000, 32'd33);
    for (int k = 0; k < 9; k++) begin
      req_valid = (k < 4) ? 4'b1010 : ((k < 7) ? 4'b0010 : 4'b0000);
      #1;
      if (k < 7) check("wrap_gnt", req_ready, wrap_gnt[k]);
      if (k >= 2) begin
        check("wrap_rv", resp_valid, wrap_gnt[k-2]);
        check("wrap_f", resp_f, (wrap_gnt[k-2] == 4'b1000) ? 32'h40000000 : 32'hFFFFFFFF);
      end
      tick();
    end

    // Reset mid-flight: two ops issued, then one reset cycle drops both.
    set_req(1, 3'd3, 32'd1, 32'd1);
    req_valid = 4'b0010;
    #1;
    check("mid_gnt_a", req_ready, 4'b0010);
    tick();
    set_req(2, 3'd3, 32'd2, 32'd2);
    req_valid = 4'b0100;
    #1;
    check("mid_gnt_b", req_ready, 4'b0100);
    tick();
    rst = 1'b1;
    req_valid = '0;
    #1;
    check("mid_rst_rv", resp_valid, 0);
    check("mid_rst_rdy", req_ready, 0);
    tick();
    rst = 1'b0;
    set_req(0, 3'd3, 32'd7, 32'd8);
    req_valid = 4'hF;
    #1;
    check("mid_first_gnt", req_ready, 4'b0001);
    check("mid_drop_b", resp_valid, 0);
    tick();
    req_valid = '0;
    #1;
    check("mid_quiet", resp_valid, 0);
    tick();
    #1;
    check("mid_rv", resp_valid, 4'b0001);
    check("mid_f", resp_f, 15);
    tick();

    // Idle: nothing requested, nothing issued or returned.
    for (int k = 0; k < 10; k++) begin
      #1;
      check("idle_alu_vld", alu_valid_i, 0);
      check("idle_rv", resp_valid, 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
